// File: rtl/cassette_pkg.sv
// Shared constants and state encoding for the cassette recorder and the player status decoder.
package cassette_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PER_W  = 12;
  localparam int unsigned LEAD_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned ST_W   = 3;

  localparam logic [PER_W-1:0]  SHORT_MAX  = 12'd24;
  localparam logic [LEAD_W-1:0] LEADER_MIN = 8'd64;
  localparam logic [PER_W-1:0]  TIMEOUT    = 12'd2000;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_HUNT  = 3'd1,
    ST_SYNC  = 3'd2,
    ST_BITS  = 3'd3,
    ST_STORE = 3'd4
  } state_t;

  // Majority vote over three samples.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/cassette_rec_if.sv
// SDRAM byte-write channel between the cassette recorder (master) and the memory controller (slave).
interface cassette_rec_if;
  import cassette_pkg::*;

  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_wdata;
  logic              sdram_wr;
  logic              sdram_ack;

  modport master (output sdram_addr, sdram_wdata, sdram_wr, input sdram_ack);
  modport slave  (input sdram_addr, sdram_wdata, sdram_wr, output sdram_ack);
endinterface

// File: rtl/cas_period_meas.sv
// Cassette input conditioning and period measurement at tick rate.
// CASSETTE_REC_FILTER_EN adds a 3-sample majority filter ahead of edge detection.
module cas_period_meas
  import cassette_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clr,
  input  logic cas_in,
  output logic bit_valid_c,
  output logic bit_val_c,
  output logic timeout_c
);

  logic             cas_m;
  logic             cas_s;
  logic             cas_f;
  logic             cas_prev;
  logic             armed;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] period_c;
  logic             edge_c;

`ifdef CASSETTE_REC_FILTER_EN
  logic [2:0] hist;
  logic       filt;

  // Tick-rate majority vote; single-tick glitches never reach the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      filt <= 1'b0;
    end else if (tick) begin
      hist <= {hist[1:0], cas_s};
      filt <= maj3(hist);
    end
  end

  assign cas_f = filt;
`else
  assign cas_f = cas_s;
`endif

  assign edge_c      = tick && cas_f && !cas_prev;
  assign period_c    = (cnt == {PER_W{1'b1}}) ? cnt : cnt + PER_W'(1);
  // The first edge after a clear only arms the counter; it has no period.
  assign bit_valid_c = edge_c && armed;
  assign bit_val_c   = (period_c <= SHORT_MAX);
  assign timeout_c   = armed && (period_c >= TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cas_m    <= 1'b0;
      cas_s    <= 1'b0;
      cas_prev <= 1'b0;
      cnt      <= '0;
      armed    <= 1'b0;
    end else begin
      cas_m <= cas_in;
      cas_s <= cas_m;
      if (tick) cas_prev <= cas_f;
      if (clr) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else if (tick) begin
        if (edge_c) begin
          cnt   <= '0;
          armed <= 1'b1;
        end else begin
          cnt <= period_c;
        end
      end
    end
  end

endmodule

// File: rtl/cassette_rec.sv
// Cassette recorder: decodes the machine's pulse-width bit stream into bytes written to SDRAM.
// Optional input majority filter selected by CASSETTE_REC_FILTER_EN.
module cassette_rec
  import cassette_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Q,
  input  logic                  record,
  input  logic                  rewind,
  input  logic                  cas_in,
  cassette_rec_if.master        sdram,
  output logic                  overflow,
  output logic [ST_W-1:0]       status
);

  state_t              state, state_n;
  logic [LEAD_W-1:0]   lead_q, lead_n, lead_inc;
  logic [BIT_W-1:0]    bit_q, bit_n;
  logic [DATA_W-1:0]   sh_q, sh_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic                wr_q, wr_n;
  logic                ovf_q, ovf_n;
  logic                q_d;
  logic                rec_q, rec_n;
  logic                rew_q, rew_n;

  logic tick_c;
  logic clr_c;
  logic bit_valid_c;
  logic bit_val_c;
  logic timeout_c;

  assign tick_c = Q && !q_d;
  // Period measurement restarts (unarmed) whenever the hunt for a leader begins.
  assign clr_c  = (state == ST_IDLE) || (state_n == ST_HUNT && state != ST_HUNT);

  cas_period_meas u_meas (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick_c),
    .clr         (clr_c),
    .cas_in      (cas_in),
    .bit_valid_c (bit_valid_c),
    .bit_val_c   (bit_val_c),
    .timeout_c   (timeout_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      lead_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ovf_q   <= 1'b0;
      q_d     <= 1'b0;
      rec_q   <= 1'b0;
      rew_q   <= 1'b0;
    end else begin
      state   <= state_n;
      lead_q  <= lead_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      wr_q    <= wr_n;
      ovf_q   <= ovf_n;
      q_d     <= Q;
      rec_q   <= rec_n;
      rew_q   <= rew_n;
    end
  end

  always_comb begin
    state_n  = state;
    lead_n   = lead_q;
    bit_n    = bit_q;
    sh_n     = sh_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    wr_n     = wr_q;
    ovf_n    = ovf_q;
    rec_n    = rec_q;
    rew_n    = rew_q;
    lead_inc = (lead_q == {LEAD_W{1'b1}}) ? lead_q : lead_q + LEAD_W'(1);

    if (tick_c) begin
      rec_n = record;
      rew_n = rewind;
    end

    // Write handshake runs every clk, independent of ticks.
    if (wr_q && sdram.sdram_ack) begin
      addr_n = addr_q + ADDR_W'(1);
      wr_n   = 1'b0;
    end

    if (tick_c && (rewind != rew_q)) begin
      state_n = ST_IDLE;
      addr_n  = '0;
      ovf_n   = 1'b0;
      wr_n    = 1'b0;
      lead_n  = '0;
      bit_n   = '0;
    end else if (tick_c && !record && rec_q) begin
      state_n = ST_IDLE;
      lead_n  = '0;
      bit_n   = '0;
    end else if (tick_c) begin
      case (state)
        ST_IDLE: begin
          if (record && !rec_q) begin
            state_n = ST_HUNT;
            lead_n  = '0;
          end
        end
        ST_HUNT: begin
          if (bit_valid_c) begin
            if (bit_val_c) begin
              lead_n = lead_inc;
              if (lead_inc >= LEADER_MIN) state_n = ST_SYNC;
            end else begin
              lead_n = '0;
            end
          end
        end
        ST_SYNC: begin
          if (timeout_c) begin
            state_n = ST_HUNT;
            lead_n  = '0;
          end else if (bit_valid_c && !bit_val_c) begin
            state_n = ST_BITS;
            bit_n   = '0;
          end
        end
        ST_BITS: begin
          if (timeout_c) begin
            state_n = ST_HUNT;
            lead_n  = '0;
            bit_n   = '0;
          end else if (bit_valid_c) begin
            sh_n  = {sh_q[DATA_W-2:0], bit_val_c};
            bit_n = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(7)) state_n = ST_STORE;
          end
        end
        ST_STORE: begin
          // A write still outstanding means there is nowhere to put this byte.
          if (wr_q && !sdram.sdram_ack) begin
            ovf_n = 1'b1;
          end else begin
            wdata_n = sh_q;
            wr_n    = 1'b1;
          end
          state_n = ST_SYNC;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign sdram.sdram_addr  = addr_q;
  assign sdram.sdram_wdata = wdata_q;
  assign sdram.sdram_wr    = wr_q;
  assign overflow          = ovf_q;
  assign status            = ST_W'(state);

endmodule

// File: tb/tb_cassette_rec.sv
// Bench for cassette_rec: directed scenarios plus randomized bit streams checked against a stream-level model.
module tb_cassette_rec;

  localparam int SHORT_MAX_TB = 24;
  localparam int LEAD_TB      = 64;
  localparam int S_IDLE = 0, S_HUNT = 1, S_SYNC = 2, S_BITS = 3;

  logic       clk = 1'b0;
  logic       reset, Q, record, rewind, cas_in;
  logic       overflow;
  logic [2:0] status;

  cassette_rec_if bus();

  cassette_rec dut (
    .clk      (clk),
    .reset    (reset),
    .Q        (Q),
    .record   (record),
    .rewind   (rewind),
    .cas_in   (cas_in),
    .sdram    (bus),
    .overflow (overflow),
    .status   (status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pq[$];
  int eb[$];
  int wa[$];
  int wd[$];
  bit auto_ack  = 1'b0;
  bit ack_req   = 1'b0;
  bit glitch    = 1'b0;
  bit fixed_per = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory-side responder: one-clk ack per write, logging what was acknowledged.
  initial begin
    bus.sdram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sdram_ack) bus.sdram_ack = 1'b0;
      else if (bus.sdram_wr && (auto_ack || ack_req)) begin
        wa.push_back(int'(bus.sdram_addr));
        wd.push_back(int'(bus.sdram_wdata));
        bus.sdram_ack = 1'b1;
      end
    end
  end

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); Q = 1'b1;
      @(negedge clk); Q = 1'b0;
    end
  endtask

  task automatic do_ack();
    ack_req = 1'b1;
    repeat (4) @(negedge clk);
    ack_req = 1'b0;
  endtask

  // Rising edge now, next rising edge p ticks later (driven by the following call).
  task automatic edge_gap(input int p);
    int hi, lo;
    hi = p / 2;
    lo = p - hi;
    cas_in = 1'b1;
    tick_n(hi);
    cas_in = 1'b0;
    if (glitch && lo >= 5) begin
      tick_n(2);
      cas_in = 1'b1;
      tick_n(1);
      cas_in = 1'b0;
      tick_n(lo - 3);
    end else begin
      tick_n(lo);
    end
  endtask

  task automatic push_bit(input bit b);
    int p;
    if (fixed_per) p = b ? 10 : 40;
    else if (b) p = ($urandom_range(3, 0) == 0) ? 24 : int'($urandom_range(23, 6));
    else        p = ($urandom_range(3, 0) == 0) ? 25 : int'($urandom_range(50, 26));
    pq.push_back(p);
  endtask

  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) push_bit(1'b1);
  endtask

  task automatic push_byte(input logic [7:0] v);
    push_bit(1'b0);
    for (int i = 7; i >= 0; i--) push_bit(v[i]);
  endtask

  // Reference: classify each period, find a 64-long run of ones, then frame start bit + 8 bits.
  task automatic model_run();
    int ones, col, acc;
    bit locked, b;
    eb.delete();
    ones = 0; locked = 1'b0; col = -1; acc = 0;
    foreach (pq[i]) begin
      b = (pq[i] <= SHORT_MAX_TB);
      if (!locked) begin
        ones = b ? ones + 1 : 0;
        if (ones >= LEAD_TB) locked = 1'b1;
      end else if (col < 0) begin
        if (!b) begin col = 0; acc = 0; end
      end else begin
        acc = ((acc << 1) | int'(b)) & 8'hFF;
        col++;
        if (col == 8) begin eb.push_back(acc); col = -1; end
      end
    end
  endtask

  task automatic send_all();
    model_run();
    foreach (pq[i]) edge_gap(pq[i]);
    edge_gap(20);
    pq.delete();
  endtask

  task automatic start_session();
    record = 1'b0;
    cas_in = 1'b0;
    tick_n(2);
    rewind = ~rewind;
    tick_n(2);
    record = 1'b1;
    tick_n(3);
    wa.delete();
    wd.delete();
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wd.size()), 32'(eb.size()));
    for (int i = 0; i < eb.size() && i < wd.size(); i++) begin
      chk({tag, "_data"}, 32'(wd[i]), 32'(eb[i]));
      chk({tag, "_addr"}, 32'(wa[i]), 32'(i));
    end
  endtask

  initial begin
    reset = 1'b1; Q = 1'b0; record = 1'b0; rewind = 1'b0; cas_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_status", 32'(status), S_IDLE);
    chk("rst_addr", 32'(bus.sdram_addr), 0);
    chk("rst_wdata", 32'(bus.sdram_wdata), 0);
    chk("rst_wr", 32'(bus.sdram_wr), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    tick_n(2);

    // Single byte A5 after a 64-bit leader.
    fixed_per = 1'b1; auto_ack = 1'b0;
    start_session();
    push_ones(64); push_byte(8'hA5); send_all();
    chk("a5_data", 32'(bus.sdram_wdata), 32'hA5);
    chk("a5_wr", 32'(bus.sdram_wr), 1);
    chk("a5_addr", 32'(bus.sdram_addr), 0);
    chk("a5_status", 32'(status), S_SYNC);
    do_ack();
    chk("a5_ack_addr", 32'(bus.sdram_addr), 1);
    chk("a5_ack_wr", 32'(bus.sdram_wr), 0);

    // 63-bit leader is not enough.
    start_session();
    push_ones(63); push_bit(1'b0); push_ones(8); send_all();
    chk("short_lead_status", 32'(status), S_HUNT);
    chk("short_lead_wr", 32'(bus.sdram_wr), 0);

    // Second byte while the first is unacknowledged.
    start_session();
    push_ones(64); push_byte(8'hA5); push_byte(8'h3C); send_all();
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_addr", 32'(bus.sdram_addr), 0);
    chk("ovf_data", 32'(bus.sdram_wdata), 32'hA5);
    chk("ovf_wr", 32'(bus.sdram_wr), 1);
    do_ack();
    chk("ovf_ack_addr", 32'(bus.sdram_addr), 1);
    chk("ovf_sticky", 32'(overflow), 1);

    // Line goes quiet after four data bits.
    auto_ack = 1'b1;
    start_session();
    push_ones(64); push_bit(1'b0);
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
    send_all();
    chk("to_pre_status", 32'(status), S_BITS);
    tick_n(2100);
    chk("to_status", 32'(status), S_HUNT);
    chk("to_wr", 32'(bus.sdram_wr), 0);
    chk("to_nwr", 32'(wd.size()), 0);

    // Rewind in the middle of a byte at address 5.
    start_session();
    push_ones(64);
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    push_bit(1'b0); push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
    send_all();
    chk_writes("rw_pre");
    chk("rw_pre_addr", 32'(bus.sdram_addr), 5);
    chk("rw_pre_status", 32'(status), S_BITS);
    rewind = ~rewind;
    tick_n(2);
    chk("rw_addr", 32'(bus.sdram_addr), 0);
    chk("rw_status", 32'(status), S_IDLE);
    chk("rw_wr", 32'(bus.sdram_wr), 0);

    // Reset while a write is pending.
    auto_ack = 1'b0;
    start_session();
    push_ones(64); push_byte(8'h5A); send_all();
    chk("rstw_pre_wr", 32'(bus.sdram_wr), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_wr", 32'(bus.sdram_wr), 0);
    chk("rstw_addr", 32'(bus.sdram_addr), 0);
    chk("rstw_status", 32'(status), S_IDLE);
    reset = 1'b0;
    tick_n(2);

    // Randomized streams: noise, leader of varying length, 1..3 bytes with idle ones between.
    fixed_per = 1'b0; auto_ack = 1'b1;
    for (int t = 0; t < 6; t++) begin
      start_session();
      for (int i = 0; i < int'($urandom_range(4, 0)); i++) push_bit(1'($urandom));
      push_ones(int'($urandom_range(70, 62)));
      for (int b = 0; b < int'($urandom_range(3, 1)); b++) begin
        push_ones(int'($urandom_range(2, 0)));
        push_byte(8'($urandom));
      end
      send_all();
      tick_n(4);
      chk_writes("rand");
      chk("rand_ovf", 32'(overflow), 0);
    end

`ifdef CASSETTE_REC_FILTER_EN
    // Single-tick glitches inside low phases must be rejected.
    fixed_per = 1'b1; auto_ack = 1'b0; glitch = 1'b1;
    start_session();
    push_ones(64); push_byte(8'hA5); send_all();
    chk("flt_data", 32'(bus.sdram_wdata), 32'hA5);
    chk("flt_wr", 32'(bus.sdram_wr), 1);
    chk("flt_addr", 32'(bus.sdram_addr), 0);
    glitch = 1'b0;
    do_ack();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
